// File: rtl/pixel_reader_hwc.sv
// HWC image address walker: emits one buffer read address per beat
// Ports: clk, reset_n, start/mode/abort/ready in; valid/addr/row/col/ch/first/last/busy/done out
module pixel_reader_hwc #(
  parameter int IMG_W    = 96,
  parameter int IMG_H    = 96,
  parameter int CHANNELS = 1,
  parameter int ADDR_W   = (IMG_W * IMG_H * CHANNELS > 1)
                         ? $clog2(IMG_W * IMG_H * CHANNELS) : 1,
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int HW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  input  logic              ready,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [RW-1:0]     row,
  output logic [CW-1:0]     col,
  output logic [HW-1:0]     ch,
  output logic              first,
  output logic              last,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  localparam logic [RW-1:0] R_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_MAX = CW'(IMG_W - 1);
  localparam logic [HW-1:0] H_MAX = HW'(CHANNELS - 1);
  localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(CHANNELS);

  state_t state_q, state_d;
  logic mode_q, mode_d;
  logic done_q, done_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [HW-1:0] ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic row_end, col_end, ch_end, at_last;

  assign row_end = (row_q == R_MAX);
  assign col_end = (col_q == C_MAX);
  assign ch_end  = (ch_q == H_MAX);
  assign at_last = row_end && col_end && ch_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      ch_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    row_d   = row_q;
    col_d   = col_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          mode_d  = mode;
          row_d   = '0;
          col_d   = '0;
          ch_d    = '0;
          addr_d  = '0;
        end
      end
      STREAM: begin
        // completion outranks abort on the final beat
        if (ready && at_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
          ch_d    = '0;
          addr_d  = '0;
        end else if (abort) begin
          state_d = IDLE;
          row_d   = '0;
          col_d   = '0;
          ch_d    = '0;
          addr_d  = '0;
        end else if (ready) begin
          unique case (1'b1)
            !mode_q: begin
              addr_d = addr_q + ADDR_W'(1);
              if (!ch_end) begin
                ch_d = ch_q + HW'(1);
              end else begin
                ch_d = '0;
                if (!col_end) begin
                  col_d = col_q + CW'(1);
                end else begin
                  col_d = '0;
                  row_d = row_q + RW'(1);
                end
              end
            end
            mode_q: begin
              if (!col_end) begin
                col_d  = col_q + CW'(1);
                addr_d = addr_q + A_STEP;
              end else if (!row_end) begin
                col_d  = '0;
                row_d  = row_q + RW'(1);
                addr_d = addr_q + A_STEP;
              end else begin
                // next plane starts at its channel offset
                col_d  = '0;
                row_d  = '0;
                ch_d   = ch_q + HW'(1);
                addr_d = ADDR_W'(ch_q) + ADDR_W'(1);
              end
            end
          endcase
        end
      end
    endcase
  end

  assign valid = (state_q == STREAM);
  assign busy  = valid;
  assign addr  = addr_q;
  assign row   = row_q;
  assign col   = col_q;
  assign ch    = ch_q;
  assign first = valid && (row_q == '0) && (col_q == '0) && (ch_q == '0);
  assign last  = valid && at_last;
  assign done  = done_q;

endmodule

// File: tb/tb_pixel_reader_hwc.sv
// Directed bench for pixel_reader_hwc: 4x3x2 geometry plus 1x1x1
// Covers raster, channel-major, stalls, abort, back-to-back, async reset
module tb_pixel_reader_hwc;

  logic clk = 1'b0;
  logic reset_n;
  logic start, mode, abort, ready;
  logic start1;

  logic       valid, first, last, busy, done;
  logic [4:0] addr;
  logic [1:0] row, col;
  logic [0:0] ch;

  logic       valid1, first1, last1, busy1, done1;
  logic [0:0] addr1, row1, col1, ch1;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  pixel_reader_hwc #(
    .IMG_W(4), .IMG_H(3), .CHANNELS(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .abort(abort), .ready(ready), .valid(valid), .addr(addr),
    .row(row), .col(col), .ch(ch), .first(first), .last(last),
    .busy(busy), .done(done)
  );

  pixel_reader_hwc #(
    .IMG_W(1), .IMG_H(1), .CHANNELS(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .mode(mode),
    .abort(abort), .ready(ready), .valid(valid1), .addr(addr1),
    .row(row1), .col(col1), .ch(ch1), .first(first1), .last(last1),
    .busy(busy1), .done(done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  initial begin
    logic [31:0] exp_a;
    logic [31:0] prev;
    logic stalled;
    int done_cnt;
    int r;

    reset_n = 1'b0;
    start = 0; start1 = 0; mode = 0; abort = 0; ready = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_first", first, 0);
    chk("rst_last", last, 0);
    chk("rst_pos", {addr, row, col, ch}, 0);

    // raster frame, ready high
    ready = 1; mode = 0; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 24; i++) begin
      chk("r_valid", valid, 1);
      chk("r_addr", addr, i);
      chk("r_first", first, (i == 0));
      chk("r_last", last, (i == 23));
      if (i == 23) chk("r_pos", {row, col, ch}, {2'd2, 2'd3, 1'b1});
      tick();
    end
    chk("r_done", done, 1);
    chk("r_valid_off", valid, 0);
    tick();
    chk("r_done_pulse", done, 0);

    // raster frame with random backpressure
    start = 1;
    tick();
    start = 0;
    exp_a = 0; stalled = 0; prev = 0; done_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        done_cnt++;
        break;
      end
      if (valid) begin
        if (stalled) chk("stall_hold", {addr, row, col, ch, first, last}, prev);
        r = $urandom_range(0, 1);
        ready = r[0];
        if (ready) begin
          chk("rnd_addr", addr, exp_a);
          exp_a++;
        end
        stalled = !ready;
        prev = {addr, row, col, ch, first, last};
      end
      tick();
    end
    chk("rnd_beats", exp_a, 24);
    chk("rnd_done", done_cnt, 1);
    tick();
    chk("rnd_done_once", done, 0);

    // abort on accepted beat 5
    ready = 1; start = 1;
    tick();
    start = 0;
    repeat (5) tick();
    chk("ab_addr5", addr, 5);
    abort = 1;
    tick();
    abort = 0;
    chk("ab_valid", valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    tick();
    chk("ab_done2", done, 0);
    start = 1;
    tick();
    start = 0;
    chk("ab_restart_addr", addr, 0);
    chk("ab_restart_first", first, 1);
    chk("ab_restart_valid", valid, 1);

    // abort with last beat, then start in the done cycle (mode 1)
    repeat (23) tick();
    chk("al_last", last, 1);
    abort = 1;
    tick();
    abort = 0;
    chk("al_done", done, 1);
    chk("al_valid", valid, 0);
    mode = 1; start = 1;
    tick();
    start = 0; mode = 0;
    for (int i = 0; i < 24; i++) begin
      chk("cm_valid", valid, 1);
      chk("cm_addr", addr, (i < 12) ? 2 * i : 2 * (i - 12) + 1);
      chk("cm_ch", ch, (i >= 12));
      chk("cm_last", last, (i == 23));
      tick();
    end
    chk("cm_done", done, 1);

    // single-beat geometry
    start1 = 1;
    tick();
    start1 = 0;
    chk("one_valid", valid1, 1);
    chk("one_fl", {first1, last1}, 2'b11);
    chk("one_addr", addr1, 0);
    tick();
    chk("one_done", done1, 1);
    chk("one_valid_off", valid1, 0);

    // async reset mid-frame
    start = 1; start1 = 1;
    tick();
    start = 0; start1 = 0;
    tick();
    chk("pre_rst_addr", addr, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out", {valid, busy, done, first, last}, 0);
    chk("arst_pos", {addr, row, col, ch}, 0);
    chk("arst_out1", {valid1, busy1, done1, first1, last1}, 0);
    reset_n = 1'b1;
    tick();
    chk("arst_idle", valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/pixel_reader_hwc.md
# pixel_reader_hwc

Address generator that walks an IMG_W×IMG_H×CHANNELS image stored HWC-interleaved in the input buffer and emits one read address per beat over a valid/ready handshake. It replaces the fixed single-channel, free-running pixel pointer with multi-channel support, two traversal orders, consumer backpressure, abort, and position/framing sideband. It sits between the frame-load controller and the input buffer read port; the downstream sliding-window/im2col logic consumes the sideband.

## Interface
- IMG_W, default 96: image width in pixels, ≥1
- IMG_H, default 96: image height in pixels, ≥1
- CHANNELS, default 1: channels per pixel, ≥1
- ADDR_W, default $clog2(IMG_W*IMG_H*CHANNELS), minimum 1: address width
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- mode  in  1  0 = raster (pixel-major, channel innermost); 1 = channel-major (channel outermost, raster within a plane); latched at start
- abort  in  1  terminate the current frame
- ready  in  1  consumer accepts the current beat
- valid  out  1  addr and sideband are valid
- addr  out  ADDR_W  buffer word address, (row*IMG_W+col)*CHANNELS+ch
- row  out  $clog2(IMG_H) (min 1)  current row
- col  out  $clog2(IMG_W) (min 1)  current column
- ch  out  $clog2(CHANNELS) (min 1)  current channel
- first  out  1  first beat of frame
- last  out  1  final beat of frame
- busy  out  1  high in STREAM
- done  out  1  one-cycle pulse after the final beat is accepted

## Operation
- States: IDLE, STREAM. Reset → IDLE.
- IDLE: if start, latch mode, clear row/col/ch/addr, go to STREAM. Other inputs ignored.
- STREAM: valid=1, busy=1. Beat accepted on valid&&ready; counters advance only on acceptance.
- mode 0 advance: ch+1; at CHANNELS-1 wrap ch→0, col+1; at IMG_W-1 wrap col→0, row+1. addr += 1.
- mode 1 advance: col+1; at IMG_W-1 wrap col→0, row+1; at IMG_H-1 wrap row→0, ch+1. addr += CHANNELS within a plane; at plane end addr = ch+1.
- first = valid && (row,col,ch all 0). last = valid && (row==IMG_H-1, col==IMG_W-1, ch==CHANNELS-1).
- Accepted beat with last=1 → IDLE; done=1 the following cycle.
- abort in STREAM → IDLE on next edge. No done pulse. The beat presented that cycle counts as transferred if ready=1.
- abort and an accepted last beat in the same cycle → completion wins; done pulses.
- start while in STREAM is ignored. abort in IDLE is ignored.
- start in the same cycle as done is accepted; the next frame begins.
- Degenerate IMG_W=IMG_H=CHANNELS=1: single beat with first=last=1.
- Total beats per frame = IMG_W*IMG_H*CHANNELS in either mode; every address visited exactly once.

## Timing
- Reset values: valid 0, busy 0, done 0, first 0, last 0, addr 0, row 0, col 0, ch 0, state IDLE. Reset assertion mid-frame takes effect immediately (asynchronous); the frame is discarded.
- All outputs are registered state or decoded from registered state only; no combinational path from ready, start or abort to any output.
- start sampled at edge N → valid=1 from cycle N+1 (1-cycle latency).
- With ready held high: one beat per cycle. last at cycle N+IMG_W*IMG_H*CHANNELS, done at the following cycle, valid=0 in that same cycle.
- valid && !ready: addr, row, col, ch, first and last hold stable. valid never drops without an accepted last beat, an abort, or a reset.

## Test plan
- IMG_W=4, IMG_H=3, CHANNELS=2, mode 0, ready=1: addr 0..23 consecutive. first on beat 0, last on beat 23 (row 2, col 3, ch 1). done one cycle after. Total 24 beats.
- Same geometry, mode 1: addr sequence 0,2,4,…,22,1,3,…,23. ch flips 0→1 after beat 11. last at addr 23.
- Random ready (≈50%) in mode 0: outputs stable during stalls. Accepted-address sequence equals the ready=1 sequence. done exactly once.
- abort asserted on accepted beat 5: next cycle valid=0, busy=0, no done. A fresh start restarts at addr 0, first=1.
- abort concurrent with the accepted last beat: done pulses. Separately, start in the done cycle: a second frame starts with valid on the next cycle.
- IMG_W=IMG_H=CHANNELS=1: one beat with addr 0, first=last=1. Also assert reset_n low mid-frame: all outputs go to reset values without waiting for a clock edge.
